// File: rtl/di_initiator.sv
// di_* bus master: turns a command stream into di_* protocol transactions.
// Optional idle timeout in XFER enabled by defining DI_INITIATOR_TIMEOUT_EN.
module di_initiator #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic        ifclk,
    input  logic        resetb,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_term,
    input  logic [31:0] cmd_addr,
    input  logic [15:0] cmd_words,
    input  logic [15:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        done,
    output logic [15:0] status,
    output logic        busy,
    output logic [15:0] di_term_addr,
    output logic [31:0] di_reg_addr,
    output logic [31:0] di_len,
    output logic        di_read_mode,
    output logic        di_read_req,
    output logic        di_read,
    output logic        di_write_mode,
    output logic        di_write,
    output logic [15:0] di_reg_datai,
    input  logic        di_read_rdy,
    input  logic        di_write_rdy,
    input  logic [15:0] di_reg_datao,
    input  logic [15:0] di_transfer_status
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_FINISH, S_DONE} state_t;

    state_t      state, state_nxt;
    logic        is_write;
    logic [15:0] remaining;
    logic        rem_nz, in_xfer, in_mode, accept, strobe, timeout_hit;

`ifdef DI_INITIATOR_TIMEOUT_EN
    logic [15:0] idle_cnt;
    logic        timed_out;

    assign timeout_hit = in_xfer && !strobe && (idle_cnt == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            idle_cnt  <= '0;
            timed_out <= 1'b0;
        end else begin
            if (!in_xfer || strobe)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 16'd1;
            if (accept)
                timed_out <= 1'b0;
            else if (timeout_hit)
                timed_out <= 1'b1;
        end
    end
`else
    // Parameter kept for drop-in compatibility; folded into a sink net.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    assign rem_nz        = (remaining != 16'd0);
    assign in_xfer       = (state == S_XFER);
    assign in_mode       = (state == S_SETUP) || in_xfer || (state == S_FINISH);
    assign cmd_ready     = resetb && (state == S_IDLE);
    assign accept        = cmd_valid && cmd_ready;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign di_write_mode = in_mode && is_write;
    assign di_read_mode  = in_mode && !is_write;
    assign di_write      = in_xfer && is_write && di_write_rdy && wr_valid && rem_nz;
    assign wr_ready      = di_write;
    assign di_reg_datai  = (in_xfer && is_write) ? wr_data : '0;
    assign di_read_req   = in_xfer && !is_write && rem_nz;
    assign di_read       = di_read_req && di_read_rdy && (!rd_valid || rd_ready);
    assign strobe        = di_write || di_read;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_SETUP;
            S_SETUP:  state_nxt = rem_nz ? S_XFER : S_FINISH;
            // Leave on the last strobe so N words take exactly N XFER cycles.
            S_XFER:   if (timeout_hit || !rem_nz || (strobe && remaining == 16'd1))
                          state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state        <= S_IDLE;
            is_write     <= 1'b0;
            remaining    <= '0;
            di_term_addr <= '0;
            di_reg_addr  <= '0;
            di_len       <= '0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            status       <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                is_write     <= cmd_write;
                remaining    <= cmd_words;
                di_term_addr <= cmd_term;
                di_reg_addr  <= cmd_addr;
                di_len       <= {15'b0, cmd_words, 1'b0};
            end else if (strobe) begin
                remaining <= remaining - 16'd1;
            end
            if (di_read) begin
                rd_valid <= 1'b1;
                rd_data  <= di_reg_datao;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
            if (state == S_FINISH) begin
`ifdef DI_INITIATOR_TIMEOUT_EN
                status <= timed_out ? 16'hFFFE : di_transfer_status;
`else
                status <= di_transfer_status;
`endif
            end
        end
    end
endmodule

// File: tb/tb_di_initiator.sv
// Self-checking bench for di_initiator: directed cases plus randomized commands
// checked against a transaction-level model (queues of words, counts, latency).
`timescale 1ns/1ps
module tb_di_initiator;
    logic        ifclk = 1'b0, resetb = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [15:0] cmd_term = '0, cmd_words = '0;
    logic [31:0] cmd_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid, rd_ready = 1'b0;
    logic        done, busy;
    logic [15:0] status, di_term_addr, di_reg_datai;
    logic [31:0] di_reg_addr, di_len;
    logic        di_read_mode, di_read_req, di_read, di_write_mode, di_write;
    logic        di_read_rdy = 1'b0, di_write_rdy = 1'b0;
    logic [15:0] di_reg_datao = '0, di_transfer_status = '0;

    int checks = 0, errors = 0;
    logic [15:0] wr_src[$], wr_seen[$], rd_exp[$];

    always #5 ifclk = ~ifclk;

    di_initiator #(.TIMEOUT_CYCLES(16'd16)) dut (
        .ifclk(ifclk), .resetb(resetb),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_term(cmd_term), .cmd_addr(cmd_addr), .cmd_words(cmd_words),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .status(status), .busy(busy),
        .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr), .di_len(di_len),
        .di_read_mode(di_read_mode), .di_read_req(di_read_req), .di_read(di_read),
        .di_write_mode(di_write_mode), .di_write(di_write), .di_reg_datai(di_reg_datai),
        .di_read_rdy(di_read_rdy), .di_write_rdy(di_write_rdy),
        .di_reg_datao(di_reg_datao), .di_transfer_status(di_transfer_status)
    );

    task automatic chk(input string nm, input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", nm, tag, obs, exp);
        end
    endtask

    // Runs one command. The cycle in which the command is presented is cycle 0.
    // stall: rd_ready forced low through that cycle; stuck: responder not ready through that cycle.
    task automatic run_cmd(input string nm, input bit wr, input logic [15:0] term, input logic [31:0] addr,
                           input logic [15:0] words, input int p_rdy, input int p_stream, input int p_cons,
                           input int stall, input int stuck, input bit fix_rd, input logic [15:0] rd_val,
                           input logic [15:0] st_val, input logic [15:0] exp_st, input int exp_strobes,
                           input int exp_lat);
        logic [15:0] exp_wr[$];
        int cyc, strobes, mode_cnt, done_idx;
        bit seen_done;
        exp_wr = wr_src;
        wr_seen.delete();
        strobes = 0; mode_cnt = 0; done_idx = -1; seen_done = 0;

        @(negedge ifclk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_term = term; cmd_addr = addr; cmd_words = words;
        di_transfer_status = st_val;
        #1;
        chk(nm, "cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge ifclk);
        cyc = 1;
        while (!seen_done && cyc < 400) begin
            @(negedge ifclk);
            cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_term = 16'($urandom);
            cmd_addr = $urandom; cmd_words = 16'($urandom);
            di_write_rdy = (cyc > stuck) && (int'($urandom_range(99)) < p_rdy);
            di_read_rdy  = (cyc > stuck) && (int'($urandom_range(99)) < p_rdy);
            wr_valid     = int'($urandom_range(99)) < p_stream;
            wr_data      = (wr_src.size() != 0) ? wr_src[0] : 16'($urandom);
            rd_ready     = (cyc > stall) && (int'($urandom_range(99)) < p_cons);
            di_reg_datao = fix_rd ? rd_val : 16'($urandom);
            #1;
            if (di_write) begin
                chk(nm, "wr_ready", 64'(wr_ready), 64'd1);
                wr_seen.push_back(di_reg_datai);
                if (wr_src.size() != 0) void'(wr_src.pop_front());
                strobes++;
            end
            if (rd_valid && rd_ready) begin
                if (rd_exp.size() == 0) chk(nm, "rd_extra", 64'(rd_valid), 64'd0);
                else chk(nm, "rd_data", 64'(rd_data), 64'(rd_exp.pop_front()));
            end
            if (di_read) begin
                rd_exp.push_back(di_reg_datao);
                strobes++;
            end
            if (wr ? di_write_mode : di_read_mode) mode_cnt++;
            if (wr ? (di_read_mode || di_read_req) : (di_write_mode || di_write))
                chk(nm, "wrong_mode", 64'd1, 64'd0);
            if (stall > 0 && cyc == stall) chk(nm, "stall_strobes", 64'(strobes), 64'd1);
`ifndef DI_INITIATOR_TIMEOUT_EN
            if (stuck > 0 && cyc == stuck) begin
                chk(nm, "stuck_busy", 64'(busy), 64'd1);
                chk(nm, "stuck_strobes", 64'(strobes), 64'd0);
            end
`endif
            if (done) begin
                seen_done = 1;
                done_idx = cyc;
                chk(nm, "busy_at_done", 64'(busy), 64'd1);
            end
            @(posedge ifclk);
            cyc++;
        end
        if (!seen_done) chk(nm, "done_timeout", 64'd0, 64'd1);

        @(negedge ifclk);
        rd_ready = 1'b1; wr_valid = 1'b0; di_write_rdy = 1'b0; di_read_rdy = 1'b0;
        #1;
        chk(nm, "busy_after", 64'(busy), 64'd0);
        chk(nm, "cmd_ready_after", 64'(cmd_ready), 64'd1);
        chk(nm, "done_after", 64'(done), 64'd0);
        chk(nm, "status", 64'(status), 64'(exp_st));
        chk(nm, "di_len", 64'(di_len), 64'(32'(words) * 2));
        chk(nm, "di_term_addr", 64'(di_term_addr), 64'(term));
        chk(nm, "di_reg_addr", 64'(di_reg_addr), 64'(addr));
        chk(nm, "strobes", 64'(strobes), 64'(exp_strobes));
        if (seen_done) chk(nm, "mode_cycles", 64'(mode_cnt), 64'(done_idx - 1));
        if (exp_lat >= 0) chk(nm, "latency", 64'(done_idx), 64'(exp_lat));
        if (wr) begin
            chk(nm, "wr_count", 64'(wr_seen.size()), 64'(exp_strobes));
            for (int i = 0; i < wr_seen.size() && i < exp_wr.size(); i++)
                chk(nm, "wr_word", 64'(wr_seen[i]), 64'(exp_wr[i]));
        end
        for (int k = 0; k < 8 && rd_exp.size() != 0; k++) begin
            if (rd_valid) chk(nm, "rd_drain", 64'(rd_data), 64'(rd_exp.pop_front()));
            @(negedge ifclk);
            #1;
        end
        chk(nm, "rd_left", 64'(rd_exp.size()), 64'd0);
        chk(nm, "rd_valid_idle", 64'(rd_valid), 64'd0);
        wr_src.delete();
        rd_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] w, st;
        bit          wr;

        #2;
        chk("reset", "cmd_ready", 64'(cmd_ready), 64'd0);
        chk("reset", "busy", 64'(busy), 64'd0);
        chk("reset", "status", 64'(status), 64'd0);
        chk("reset", "strobes", 64'({di_write, di_read, di_read_req, di_write_mode, di_read_mode}), 64'd0);
        chk("reset", "rd_valid", 64'(rd_valid), 64'd0);
        chk("reset", "di_len", 64'(di_len), 64'd0);
        repeat (3) @(posedge ifclk);
        @(negedge ifclk);
        resetb = 1'b1;
        #1;
        chk("reset", "cmd_ready_release", 64'(cmd_ready), 64'd1);

        wr_src = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        run_cmd("wr4", 1, 16'h0001, 32'h10, 16'd4, 100, 100, 100, 0, 0, 0, 16'h0,
                16'h0000, 16'h0000, 4, 7);
        run_cmd("rd_stall", 0, 16'h0001, 32'h20, 16'd3, 100, 100, 100, 20, 0, 1, 16'hBBBB,
                16'h0000, 16'h0000, 3, -1);
        run_cmd("rd_unknown", 0, 16'h00FE, 32'h4, 16'd2, 100, 100, 100, 0, 0, 1, 16'hAAAA,
                16'hFFFF, 16'hFFFF, 2, -1);
        run_cmd("wr0", 1, 16'h0001, 32'h30, 16'd0, 100, 100, 100, 0, 0, 0, 16'h0,
                16'h0005, 16'h0005, 0, 3);
`ifdef DI_INITIATOR_TIMEOUT_EN
        run_cmd("rd_stuck", 0, 16'h0002, 32'h40, 16'd2, 100, 100, 100, 0, 60, 0, 16'h0,
                16'h0000, 16'hFFFE, 0, -1);
`else
        run_cmd("rd_stuck", 0, 16'h0002, 32'h40, 16'd2, 100, 100, 100, 0, 60, 0, 16'h0,
                16'h0000, 16'h0000, 2, -1);
`endif

        // Reset during the second of four write words.
        @(negedge ifclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_term = 16'h0001; cmd_addr = 32'h50; cmd_words = 16'd4;
        di_write_rdy = 1'b1; wr_valid = 1'b1; wr_data = 16'h1111;
        @(posedge ifclk);
        @(negedge ifclk);
        cmd_valid = 1'b0;
        @(posedge ifclk);
        @(negedge ifclk);
        #1;
        chk("rst_mid", "first_word", 64'(di_write), 64'd1);
        @(posedge ifclk);
        @(negedge ifclk);
        wr_data = 16'h2222;
        #1;
        chk("rst_mid", "second_word", 64'(di_write), 64'd1);
        resetb = 1'b0;
        #1;
        chk("rst_mid", "di_write", 64'(di_write), 64'd0);
        chk("rst_mid", "modes", 64'({di_write_mode, di_read_mode, di_read_req, di_read}), 64'd0);
        chk("rst_mid", "wr_ready", 64'(wr_ready), 64'd0);
        chk("rst_mid", "busy", 64'(busy), 64'd0);
        chk("rst_mid", "cmd_ready", 64'(cmd_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge ifclk);
            #1;
            chk("rst_mid", "no_done", 64'(done), 64'd0);
        end
        resetb = 1'b1;
        wr_valid = 1'b0; di_write_rdy = 1'b0;
        @(negedge ifclk);
        #1;
        chk("rst_mid", "no_done_after", 64'(done), 64'd0);
        chk("rst_mid", "idle", 64'(busy), 64'd0);
        wr_src = '{16'h5555, 16'h6666};
        run_cmd("after_rst", 1, 16'h0003, 32'h60, 16'd2, 100, 100, 100, 0, 0, 0, 16'h0,
                16'h0000, 16'h0000, 2, 5);

        for (int n = 0; n < 20; n++) begin
            wr = 1'($urandom);
            w  = 16'($urandom_range(6));
            st = 16'($urandom);
            if (wr) for (int i = 0; i < int'(w); i++) wr_src.push_back(16'($urandom));
            run_cmd("rand", wr, 16'($urandom), $urandom, w,
                    int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                    int'($urandom_range(100, 30)), 0, 0, 0, 16'h0, st, st, int'(w), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
